// File: rtl/frodo_acc_pkg.sv
// Shared types and defaults for the carry-save accumulator.
// State encoding plus default datapath widths.
package frodo_acc_pkg;

  localparam int ACC_WIDTH = 16;
  localparam int ACC_CNT_W = 12;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    RESOLVE,
    OUT
  } acc_state_t;

endpackage

// File: rtl/csa_three_input.sv
// 3:2 carry-save compressor; i_mode=1 inverts c and injects
// a carry-in at bit 0 so the pair resolves to a+b-c.
module csa_three_input #(
  parameter int W = 16
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic [W-1:0] i_c,
  input  logic         i_mode,
  output logic [W-1:0] o_sum,
  output logic [W-1:0] o_carry
);

  logic [W-1:0] cc;
  logic [W-2:0] maj;

  assign cc = i_c ^ {W{i_mode}};
  assign o_sum = i_a ^ i_b ^ cc;

  // top majority bit would land at 2^W and is dropped
  assign maj = (i_a[W-2:0] & i_b[W-2:0])
             | (i_a[W-2:0] & cc[W-2:0])
             | (i_b[W-2:0] & cc[W-2:0]);

  assign o_carry = {maj, i_mode};

endmodule

// File: rtl/csa_accum_ctrl.sv
// Multi-operand accumulator: carry-save folding per operand,
// one carry-propagate add at the end of the run.
module csa_accum_ctrl
  import frodo_acc_pkg::*;
#(
  parameter int WIDTH = ACC_WIDTH,
  parameter int CNT_W = ACC_CNT_W
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_len,
  input  logic [WIDTH-1:0] i_init,
  input  logic             i_op_valid,
  input  logic [WIDTH-1:0] i_op,
  output logic             o_op_ready,
  output logic             o_res_valid,
  output logic [WIDTH-1:0] o_res,
  input  logic             i_res_ready,
  output logic             o_busy
);

  acc_state_t       state_q;
  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] carry_q;
  logic [WIDTH-1:0] res_q;
  logic [CNT_W-1:0] rem_q;
  logic [WIDTH-1:0] csa_sum;
  logic [WIDTH-1:0] csa_carry;

  csa_three_input #(
    .W(WIDTH)
  ) u_csa (
    .i_a    (sum_q),
    .i_b    (carry_q),
    .i_c    (i_op),
    .i_mode (1'b0),
    .o_sum  (csa_sum),
    .o_carry(csa_carry)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      sum_q   <= '0;
      carry_q <= '0;
      res_q   <= '0;
      rem_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (i_start) begin
            sum_q   <= i_init;
            carry_q <= '0;
            rem_q   <= i_len;
            state_q <= (i_len != '0) ? ACCUM : RESOLVE;
          end
        end
        ACCUM: begin
          if (i_op_valid) begin
            sum_q   <= csa_sum;
            carry_q <= csa_carry;
            rem_q   <= rem_q - 1'b1;
            if (rem_q == CNT_W'(1)) begin
              state_q <= RESOLVE;
            end
          end
        end
        RESOLVE: begin
          res_q   <= sum_q + carry_q;
          state_q <= OUT;
        end
        OUT: begin
          if (i_res_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_op_ready  = (state_q == ACCUM);
  assign o_res_valid = (state_q == OUT);
  assign o_busy      = (state_q != IDLE);
  assign o_res       = res_q;

endmodule

// File: tb/tb_csa_accum_ctrl.sv
// Scoreboard bench for csa_accum_ctrl.
// Inputs driven and outputs sampled on the falling edge.
module tb_csa_accum_ctrl;

  typedef logic [15:0] wq_t[$];
  typedef bit          pq_t[$];

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [11:0] len;
  logic [15:0] init;
  logic        op_valid;
  logic [15:0] op;
  logic        op_ready;
  logic        res_valid;
  logic [15:0] res;
  logic        res_ready;
  logic        busy;

  int          n_chk;
  int          n_err;
  logic [15:0] sb[$];

  csa_accum_ctrl dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_start    (start),
    .i_len      (len),
    .i_init     (init),
    .i_op_valid (op_valid),
    .i_op       (op),
    .o_op_ready (op_ready),
    .o_res_valid(res_valid),
    .o_res      (res),
    .i_res_ready(res_ready),
    .o_busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic start_run(input logic [15:0] i0,
                           input logic [11:0] l,
                           input logic [15:0] exp);
    @(negedge clk);
    start = 1'b1;
    init  = i0;
    len   = l;
    sb.push_back(exp);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("op_ready_after_start", op_ready, l != 0);
  endtask

  // already at the negedge after the start edge on entry
  task automatic feed(input wq_t ops, input pq_t pat, input int start_at);
    int idx = 0;
    int p = 0;
    bit v;
    while (idx < ops.size()) begin
      if (p > 0) @(negedge clk);
      v = (p < pat.size()) ? pat[p] : 1'b1;
      chk("op_ready_in_accum", op_ready, 1);
      chk("busy_in_accum", busy, 1);
      start    = (p == start_at);
      len      = 12'd0;
      init     = 16'hdead;
      op_valid = v;
      op       = v ? ops[idx] : 16'($urandom);
      if (v) idx++;
      p++;
    end
    @(negedge clk);
    op_valid = 1'b0;
    start    = 1'b0;
    chk("op_ready_resolve", op_ready, 0);
    chk("res_valid_resolve", res_valid, 0);
    @(negedge clk);
    chk("res_valid_k2", res_valid, 1);
  endtask

  task automatic drain(input int delay, input bit poke_start);
    logic [15:0] hold;
    logic [15:0] exp;
    int t = 0;
    while (!res_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("res_valid_timeout", res_valid, 1);
    hold = res;
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      chk("res_hold_valid", res_valid, 1);
      chk("res_hold_stable", res, hold);
    end
    exp = (sb.size() != 0) ? sb.pop_front() : 16'hxxxx;
    chk("res_value", res, exp);
    res_ready = 1'b1;
    start     = poke_start;
    len       = 12'd0;
    init      = 16'hbeef;
    @(negedge clk);
    res_ready = 1'b0;
    start     = 1'b0;
    chk("idle_after_out", busy, 0);
    chk("res_valid_after_out", res_valid, 0);
    @(negedge clk);
    chk("start_ignored_out", busy, 0);
  endtask

  initial begin
    wq_t ops;
    pq_t pat;
    n_chk     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    len       = '0;
    init      = '0;
    op_valid  = 1'b0;
    op        = '0;
    res_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_op_ready", op_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res", res, 0);
    rst_n = 1'b1;

    // basic run
    start_run(16'h0, 12'd3, 16'd6);
    ops = '{16'd1, 16'd2, 16'd3};
    pat = '{};
    feed(ops, pat, -1);
    drain(0, 1'b0);

    // seed and wrap
    start_run(16'hffff, 12'd2, 16'h8000);
    ops = '{16'h0001, 16'h8000};
    feed(ops, pat, -1);
    drain(0, 1'b0);

    // bubbles, mid-accum start pulse, backpressure, start at OUT handshake
    start_run(16'h0, 12'd4, 16'd26);
    ops = '{16'd5, 16'd6, 16'd7, 16'd8};
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    feed(ops, pat, 2);
    drain(5, 1'b1);

    // larger random-ish run with wrap
    begin
      logic [15:0] acc;
      acc = 16'h7a31;
      ops = '{};
      for (int i = 0; i < 9; i++) begin
        ops.push_back(16'($urandom));
        acc = acc + ops[i];
      end
      pat = '{};
      start_run(16'h7a31, 12'd9, acc);
      feed(ops, pat, -1);
      drain(2, 1'b0);
    end

    // zero length
    start_run(16'h1234, 12'd0, 16'h1234);
    chk("zl_res_valid_t1", res_valid, 0);
    @(negedge clk);
    chk("zl_res_valid_t2", res_valid, 1);
    chk("zl_op_ready", op_ready, 0);
    drain(0, 1'b0);

    // reset mid-run
    start_run(16'h0, 12'd5, 16'h0);
    op_valid = 1'b1;
    op       = 16'd9;
    @(negedge clk);
    op       = 16'd11;
    @(negedge clk);
    op_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    void'(sb.pop_back());
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_op_ready", op_ready, 0);
    chk("mid_rst_res_valid", res_valid, 0);
    chk("mid_rst_res", res, 0);
    @(negedge clk);
    rst_n = 1'b1;
    start_run(16'h0, 12'd1, 16'd7);
    ops = '{16'd7};
    pat = '{};
    feed(ops, pat, -1);
    drain(0, 1'b0);

    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
